// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  localparam int AW_DEFAULT     = 6;   // instruction-memory word-address width
  localparam int HDR_BYTES      = 2;   // big-endian 16-bit word count precedes the image
  localparam int BYTES_PER_WORD = 4;   // bytes assembled into one instruction word

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - big-endian byte-to-word assembler
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   byte_valid : a data byte is accepted this cycle
//   byte_data  : the accepted byte
//   word_next  : bytes seen so far plus byte_data; first byte lands in [31:24]
//   word_last  : byte_data completes the current word
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        word_last
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  // Only the three oldest bytes need to be remembered; the fourth is
  // appended combinationally so the word is available on its accept cycle.
  logic [23:0] hist_q, hist_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_next = {hist_q, byte_data};
    word_last = byte_valid && (cnt_q == LAST_IDX);
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    if (byte_valid) begin
      hist_d = word_next[23:0];
      cnt_d  = cnt_q + 2'd1;  // wraps 3 -> 0 at word boundary
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and releases the CPU
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   in_valid  : loader byte present
//   in_data   : loader byte
//   in_ready  : loader byte accepted when in_valid and in_ready are both high
//   im_we     : one-cycle instruction-memory write strobe per word
//   im_addr   : instruction-memory word address
//   im_wdata  : instruction word to write
//   cpu_rst   : active-low CPU reset, released only once the image is loaded
//   done      : image loaded, CPU released
//   err       : header rejected, CPU held in reset
//
// Stream format: 16-bit big-endian word count N, then 4*N bytes, each word
// big-endian. N must be 1..2^AW so the image never wraps the memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [7:0]    hdr_hi_q, hdr_hi_d;
  logic [15:0]   n_q, n_d;
  // One extra bit so the index can reach N = 2^AW after the last write.
  logic [AW:0]   word_idx_q, word_idx_d;
  logic          in_ready_q, in_ready_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          asm_valid;
  logic [31:0]   asm_word;
  logic          asm_last;
  logic [15:0]   n_new;
  logic          n_bad;
  logic [AW:0]   idx_next;
  logic          idx_at_n;

  assign xfer      = in_valid && in_ready_q;
  assign asm_valid = xfer && (state_q == ST_DATA);

  imem_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (asm_valid),
    .byte_data  (in_data),
    .word_next  (asm_word),
    .word_last  (asm_last)
  );

  assign n_new    = {hdr_hi_q, in_data};
  assign n_bad    = (n_new == 16'd0) || ({1'b0, n_new} > (17'd1 << AW));
  assign idx_next = word_idx_q + {{AW{1'b0}}, 1'b1};
  assign idx_at_n = (17'(idx_next) == 17'(n_q));

  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      ST_HDR_HI: begin
        if (xfer) begin
          hdr_hi_d = in_data;
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          n_d     = n_new;
          state_d = n_bad ? ST_ERR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (asm_last) begin
          im_addr_d  = word_idx_q[AW-1:0];
          im_wdata_d = asm_word;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_idx_d = idx_next;
        state_d    = idx_at_n ? ST_DONE : ST_DATA;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_HDR_HI;
    endcase

    // All outputs are registered from the next state so they change on the
    // same edge as the state they describe.
    in_ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) || (state_d == ST_DATA);
    im_we_d    = (state_d == ST_WRITE);
    cpu_rst_d  = (state_d == ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  // in_ready resets to 0 and only rises on the first edge with rst high, so
  // no byte can slip in while reset is still asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HDR_HI;
      hdr_hi_q   <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int            tests = 0;
  int            fails = 0;
  int            wr_n  = 0;
  logic [AW-1:0] wr_addr [0:127];
  logic [31:0]   wr_data [0:127];
  logic [31:0]   w3 [0:2];

  imem_loader #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Write log: one entry per cycle with im_we high.
  always @(negedge clk) begin
    if (im_we === 1'b1 && wr_n < 128) begin
      wr_addr[wr_n] = im_addr;
      wr_data[wr_n] = im_wdata;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_im_we"},    32'(im_we),    32'd0);
    chk({tag, "_im_addr"},  32'(im_addr),  32'd0);
    chk({tag, "_im_wdata"}, im_wdata,      32'd0);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    wr_n = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8]);
      if (gaps) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] mk(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b + 8'd17, 8'h5a};
  endfunction

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b1;
    @(negedge clk);
    chk("por_ready_after", 32'(in_ready), 32'd1);

    // Single word image 00 01 20 08 00 05
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    chk("w1_we",       32'(im_we),    32'd1);
    chk("w1_addr",     32'(im_addr),  32'd0);
    chk("w1_data",     im_wdata,      32'h2008_0005);
    chk("w1_ready_wr", 32'(in_ready), 32'd0);
    chk("w1_cpu_wr",   32'(cpu_rst),  32'd0);
    in_valid = 1'b1;
    in_data  = 8'hff;
    @(negedge clk);
    chk("w1_done",     32'(done),     32'd1);
    chk("w1_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("w1_we_off",   32'(im_we),    32'd0);
    repeat (3) @(negedge clk);
    chk("w1_ready_dn", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    chk("w1_count",    32'(wr_n),     32'd1);
    chk("w1_done_hold",32'(done),     32'd1);
    chk("w1_err",      32'(err),      32'd0);

    // Three words with random stalls
    w3[0] = 32'h1122_3344;
    w3[1] = 32'h5566_7788;
    w3[2] = 32'h99aa_bbcc;
    do_reset();
    send_byte(8'h00);
    idle(3);
    send_byte(8'h03);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send_word(w3[i], 1'b1);
      if (i < 2) chk("w3_not_done", 32'(done), 32'd0);
    end
    wait_done();
    chk("w3_count", 32'(wr_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("w3_addr", 32'(wr_addr[i]), 32'(i));
      chk("w3_data", wr_data[i], w3[i]);
    end
    chk("w3_cpu_rst", 32'(cpu_rst), 32'd1);

    // Header count 0 is rejected
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("n0_err",     32'(err),      32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst),  32'd0);
    chk("n0_ready",   32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h12;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("n0_no_we",   32'(wr_n),     32'd0);
    chk("n0_err_hold",32'(err),      32'd1);
    chk("n0_done",    32'(done),     32'd0);

    // Header count 2^AW + 1 is rejected
    do_reset();
    send_byte(8'h00);
    send_byte(8'h41);
    chk("n65_err",     32'(err),      32'd1);
    chk("n65_cpu_rst", 32'(cpu_rst),  32'd0);
    chk("n65_ready",   32'(in_ready), 32'd0);
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("n65_no_we",   32'(wr_n),     32'd0);

    // Full memory, 64 words
    do_reset();
    send_byte(8'h00);
    send_byte(8'h40);
    chk("n64_err", 32'(err), 32'd0);
    for (int i = 0; i < 64; i++) begin
      send_word(mk(i), 1'b0);
      if (i == 62) chk("n64_cpu_hold", 32'(cpu_rst), 32'd0);
    end
    wait_done();
    chk("n64_count", 32'(wr_n), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk("n64_addr", 32'(wr_addr[i]), 32'(i));
      chk("n64_data", wr_data[i], mk(i));
    end
    chk("n64_last_addr", 32'(im_addr), 32'd63);

    // Reset in the middle of a word
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'haa);
    send_byte(8'hbb);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid");
    chk("mid_no_we", 32'(wr_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(in_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0102_0304, 1'b0);
    wait_done();
    chk("mid_count", 32'(wr_n), 32'd1);
    chk("mid_addr",  32'(wr_addr[0]), 32'd0);
    chk("mid_data",  wr_data[0], 32'h0102_0304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 AW, default 6: instruction-memory word-address width; capacity 2^AW words.
REQ-002 clk  input  1: single system clock; all logic on rising edge.
REQ-003 rst  input  1: reset, synchronous, active-low.
REQ-004 in_valid  input  1: loader byte stream, byte present.
REQ-005 in_data  input  8: loader byte stream data.
REQ-006 in_ready  output  1: loader may accept a byte this cycle.
REQ-007 im_we  output  1: instruction-memory write strobe, one-cycle pulse per word.
REQ-008 im_addr  output  AW: instruction-memory word address.
REQ-009 im_wdata  output  32: instruction word to write.
REQ-010 cpu_rst  output  1: active-low reset to the R/I/J CPU; low while loading.
REQ-011 done  output  1: program loaded, CPU released.
REQ-012 err  output  1: header rejected, CPU held in reset.

Function
REQ-013 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-014 FSM states SHALL be HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
REQ-015 HDR_HI SHALL capture the count high byte and go to HDR_LO; HDR_LO SHALL capture the low byte, forming the 16-bit word count N.
REQ-016 On leaving HDR_LO: N=0 or N>2^AW -> ERR; otherwise -> DATA.
REQ-017 In DATA, bytes SHALL assemble big-endian (first byte -> im_wdata[31:24]); the 2-bit byte counter wraps 3->0.
REQ-018 Acceptance of the 4th byte SHALL move the FSM to WRITE; im_we=1 for exactly the next cycle, im_wdata = assembled word, im_addr = word index.
REQ-019 in_ready SHALL be 1 in HDR_HI, HDR_LO, DATA; 0 in WRITE, DONE, ERR.
REQ-020 After WRITE, the word index SHALL increment; if it equals N -> DONE, else -> DATA.
REQ-021 First word SHALL go to im_addr=0; addresses strictly sequential; no wrap (bounded by REQ-016).
REQ-022 DONE: cpu_rst=1, done=1, held until reset; further in_valid is ignored.
REQ-023 ERR: cpu_rst=0, err=1, held until reset; no im_we pulses.
REQ-024 cpu_rst SHALL be registered and rise on the clock edge entering DONE; it is never 1 in any other state.
REQ-025 im_we SHALL be 0 in every state except WRITE; im_addr/im_wdata hold their last values elsewhere.
REQ-026 in_valid held low for any number of cycles SHALL stall the FSM without state change.

Reset
REQ-027 rst=0 at a clock edge SHALL force: state=HDR_HI, byte counter=0, word index=0, N=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=0, done=0, err=0.
REQ-028 Reset mid-load SHALL abandon the partial word with no write; a fresh header is then expected.
REQ-029 in_ready SHALL be 0 during reset cycles and 1 on the first cycle after rst=1.

Structure
REQ-030 Shared package: state enumeration, AW default, header byte count (2), bytes-per-word (4).
REQ-031 Single module; byte-to-word assembler is the one natural sub-module (word_assembler), optional.
REQ-032 Estimated size 120-250 lines RTL; no memories inside the block.

Verification
REQ-033 Bytes 00 01 20 08 00 05 after reset -> one im_we pulse, im_addr=0, im_wdata=0x20080005, then done=1, cpu_rst=1.
REQ-034 Header 00 03 plus 12 bytes, in_valid toggled randomly -> exactly 3 im_we pulses at addresses 0,1,2, correct words, done after third.
REQ-035 Header 00 00 -> err=1, cpu_rst=0, in_ready=0, no im_we; same for 00 41 with AW=6.
REQ-036 Header 00 40 (AW=6), 256 bytes -> 64 writes, last at im_addr=63, done=1.
REQ-037 rst=0 after 2 data bytes of word 1 -> no write, all outputs at reset values; reload 00 01 + 4 bytes -> write at im_addr=0.
REQ-038 Byte offered during WRITE/DONE -> not accepted (in_ready=0), state unchanged.
